// File: rtl/prog_seq.sv
// Program sequencer: drives the instruction ROM address. Supports next, absolute
// and relative conditional branches, call/return through a return-address stack,
// pipeline stall and a sticky halt. All outputs come straight from registers.
module prog_seq #(
    parameter int unsigned L  = 10,
    parameter int unsigned D  = 4,
    parameter int unsigned OW = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   En,
    input  logic                   Stall,
    input  logic [2:0]             Op,
    input  logic                   Cond,
    input  logic [L-1:0]           Target,
    input  logic [OW-1:0]          Offset,
    output logic [L-1:0]           ProgCtr,
    output logic [$clog2(D+1)-1:0] SDepth,
    output logic                   StackErr,
    output logic                   Halted
);

    localparam int unsigned SW = $clog2(D + 1);
    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_BREL = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [L-1:0]  pc_q, pc_d;
    logic [SW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic          push;
    logic [L-1:0]  stack_q [D];

    op_e           op;
    logic [L-1:0]  pc_inc;
    logic [L-1:0]  off_ext;
    logic [L-1:0]  pc_rel;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [L-1:0]  stack_top;

    // Decoded op and candidate next addresses; wrap modulo 2^L falls out of the L-bit adds.
    assign op        = op_e'(Op);
    assign pc_inc    = pc_q + L'(1);
    assign off_ext   = L'(signed'(Offset));
    assign pc_rel    = pc_q + off_ext;
    assign wr_idx    = IW'(depth_q);
    assign rd_idx    = IW'(depth_q - SW'(1));
    assign stack_top = stack_q[rd_idx];

    // State register: synchronous reset has top priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents are don't-care after reset, only depth matters.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    // Next-state logic: disabled, halted or stalled cycles hold everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        if (En && (state_q == ST_RUN) && !Stall) begin
            case (op)
                OP_JUMP: pc_d = Cond ? Target : pc_inc;
                OP_BREL: pc_d = Cond ? pc_rel : pc_inc;
                OP_CALL: begin
                    if (depth_q < SW'(D)) begin
                        push    = 1'b1;
                        depth_d = depth_q + SW'(1);
                        pc_d    = Target;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (depth_q != '0) begin
                        pc_d    = stack_top;
                        depth_d = depth_q - SW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_HALT: state_d = ST_HALT;
                default: pc_d = pc_inc;
            endcase
        end
    end

    assign ProgCtr  = pc_q;
    assign SDepth   = depth_q;
    assign StackErr = err_q;
    assign Halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_prog_seq.sv
// Directed and random stimulus for prog_seq against a queue-based reference model.
module tb_prog_seq;

    localparam int unsigned L  = 10;
    localparam int unsigned D  = 4;
    localparam int unsigned OW = 8;
    localparam int unsigned SW = $clog2(D + 1);
    localparam int          PCMOD = 1 << L;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          En = 1'b0;
    logic          Stall = 1'b0;
    logic [2:0]    Op = 3'd0;
    logic          Cond = 1'b0;
    logic [L-1:0]  Target = '0;
    logic [OW-1:0] Offset = '0;
    logic [L-1:0]  ProgCtr;
    logic [SW-1:0] SDepth;
    logic          StackErr;
    logic          Halted;

    prog_seq #(.L(L), .D(D), .OW(OW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Stall    (Stall),
        .Op       (Op),
        .Cond     (Cond),
        .Target   (Target),
        .Offset   (Offset),
        .ProgCtr  (ProgCtr),
        .SDepth   (SDepth),
        .StackErr (StackErr),
        .Halted   (Halted)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc   = 0;
    int m_stk[$];
    bit m_err  = 1'b0;
    bit m_halt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs 1ns after the edge.
    task automatic cyc(input bit rst, input bit en, input bit stl, input int op,
                       input bit cnd, input int tgt, input int off, input string tag);
        Reset  = rst;
        En     = en;
        Stall  = stl;
        Op     = 3'(op);
        Cond   = cnd;
        Target = L'(tgt);
        Offset = OW'(off);
        @(posedge Clk);
        if (rst) begin
            m_pc = 0; m_stk.delete(); m_err = 1'b0; m_halt = 1'b0;
        end else if (en && !m_halt && !stl) begin
            case (op)
                1: m_pc = cnd ? (tgt % PCMOD) : (m_pc + 1) % PCMOD;
                2: m_pc = cnd ? (((m_pc + off) % PCMOD) + PCMOD) % PCMOD : (m_pc + 1) % PCMOD;
                3: begin
                    if (m_stk.size() < D) begin
                        m_stk.push_back((m_pc + 1) % PCMOD);
                        m_pc = tgt % PCMOD;
                    end else m_err = 1'b1;
                end
                4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else m_err = 1'b1;
                end
                5: m_halt = 1'b1;
                default: m_pc = (m_pc + 1) % PCMOD;
            endcase
        end
        #1;
        chk({tag, ".pc"},    32'(ProgCtr),  32'(m_pc));
        chk({tag, ".depth"}, 32'(SDepth),   32'(m_stk.size()));
        chk({tag, ".err"},   32'(StackErr), 32'(m_err));
        chk({tag, ".halt"},  32'(Halted),   32'(m_halt));
    endtask

    initial begin
        int r;
        int op;
        int off;
        #2;
        // 1: count, hold with En low, wrap at 2^L
        cyc(1, 0, 0, 0, 0, 0, 0, "rst");
        chk("rst.pc_const", 32'(ProgCtr), 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, "next");
        chk("next5_const", 32'(ProgCtr), 32'd5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, "en_low");
        chk("en_low_const", 32'(ProgCtr), 32'd5);
        cyc(0, 1, 0, 1, 1, 1023, 0, "jmp1023");
        cyc(0, 1, 0, 0, 0, 0, 0, "wrap");
        chk("wrap_const", 32'(ProgCtr), 32'd0);

        // 2: relative and absolute branches
        cyc(0, 1, 0, 1, 1, 100, 0, "jmp100");
        cyc(0, 1, 0, 2, 1, 0, -4, "brel_neg");
        chk("brel_neg_const", 32'(ProgCtr), 32'd96);
        cyc(0, 1, 0, 2, 1, 0, 16, "brel_pos");
        cyc(0, 1, 0, 2, 0, 0, 16, "brel_nc");
        cyc(0, 1, 0, 1, 0, 500, 0, "jmp_nc");
        chk("jmp_nc_const", 32'(ProgCtr), 32'd114);
        cyc(0, 1, 0, 1, 1, 500, 0, "jmp500");
        cyc(0, 1, 0, 2, 1, 0, 0, "selfloop");

        // 3: nested call/return
        cyc(0, 1, 0, 1, 1, 10, 0, "jmp10");
        cyc(0, 1, 0, 3, 0, 200, 0, "call200");
        cyc(0, 1, 0, 3, 0, 300, 0, "call300");
        cyc(0, 1, 0, 4, 0, 0, 0, "ret1");
        chk("ret1_const", 32'(ProgCtr), 32'd201);
        cyc(0, 1, 0, 4, 0, 0, 0, "ret2");
        chk("ret2_const", 32'(ProgCtr), 32'd11);

        // 4: overflow then underflow
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3, 0, 50, 0, "call_fill");
        cyc(0, 1, 0, 3, 0, 50, 0, "call_ovf");
        chk("ovf_err_const", 32'(StackErr), 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 0, "rst2");
        cyc(0, 1, 0, 4, 0, 0, 0, "ret_unf");

        // 5: stall then halt
        cyc(1, 0, 0, 0, 0, 0, 0, "rst3");
        cyc(0, 1, 0, 1, 1, 7, 0, "jmp7");
        cyc(0, 1, 1, 3, 0, 300, 0, "stall_call");
        cyc(0, 1, 0, 5, 0, 0, 0, "halt");
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, i % 2, 1, 900, 0, "halted");
        chk("halted_const", 32'(ProgCtr), 32'd7);

        // 6: reset overrides everything
        cyc(1, 0, 0, 0, 0, 0, 0, "rst4");
        cyc(0, 1, 0, 3, 0, 20, 0, "call20");
        cyc(0, 1, 0, 3, 0, 30, 0, "call30");
        cyc(0, 1, 0, 5, 0, 0, 0, "halt2");
        cyc(1, 1, 0, 3, 0, 40, 0, "rst_prio");
        cyc(0, 1, 0, 4, 0, 0, 0, "ret_after_rst");

        // Random mix
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25) op = 0;
            else if (r < 40) op = 1;
            else if (r < 60) op = 2;
            else if (r < 75) op = 3;
            else if (r < 92) op = 4;
            else if (r < 94) op = 5;
            else op = $urandom_range(6, 7);
            off = $urandom_range(0, 255);
            if (off > 127) off -= 256;
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 7) == 0), op, 1'($urandom_range(0, 1)),
                $urandom_range(0, PCMOD - 1), off, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
